// File: rtl/bus_xfer_seq.sv
// Register-transfer sequencer: drives one source onto the bus for SETTLE cycles,
// then strobes one destination load. All outputs come straight from flops.
module bus_xfer_seq #(
    parameter int SETTLE = 1
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  src_sel,
    input  logic [4:0]  dst_sel,
    output logic [23:0] out_en,
    output logic [23:0] in_en,
    output logic        done,
    output logic        err,
    output logic [15:0] xfer_count
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [4:0] MAX_CODE   = 5'd23;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOAD,
        ERR
    } state_t;

    state_t      state, state_next;
    logic [4:0]  src_q, dst_q, src_next, dst_next;
    logic [3:0]  settle_cnt, settle_next;
    logic [23:0] out_next, in_next;
    logic        done_next, err_next, ready_next;
    logic [15:0] count_next;

    // Next-state and next-output values; outputs are registered below, so the
    // decoded enables for a cycle are computed from the state being entered.
    always_comb begin
        state_next  = state;
        src_next    = src_q;
        dst_next    = dst_q;
        settle_next = settle_cnt;
        out_next    = '0;
        in_next     = '0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        count_next  = xfer_count;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if ((src_sel > MAX_CODE) || (dst_sel > MAX_CODE)) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        state_next  = DRIVE;
                        src_next    = src_sel;
                        dst_next    = dst_sel;
                        settle_next = 4'd1;
                        out_next    = 24'd1 << src_sel;
                    end
                end
            end
            DRIVE: begin
                out_next = 24'd1 << src_q;
                if (settle_cnt == SETTLE_CNT) begin
                    state_next = LOAD;
                    in_next    = 24'd1 << dst_q;
                    done_next  = 1'b1;
                end else begin
                    settle_next = settle_cnt + 4'd1;
                end
            end
            LOAD: begin
                state_next = IDLE;
                count_next = xfer_count + 16'd1;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

    // Reset leaves req_ready low; it rises on the first edge after release.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            settle_cnt <= '0;
            out_en     <= '0;
            in_en      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            req_ready  <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_next;
            src_q      <= src_next;
            dst_q      <= dst_next;
            settle_cnt <= settle_next;
            out_en     <= out_next;
            in_en      <= in_next;
            done       <= done_next;
            err        <= err_next;
            req_ready  <= ready_next;
            xfer_count <= count_next;
        end
    end

endmodule
